// File: rtl/shift_ring_reg.sv
// shift_ring_reg: WIDTH x DEPTH shift/rotate chain with parallel load and counted burst engine
module shift_ring_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic                   dir,
  input  logic [WIDTH-1:0]       sin,
  input  logic [WIDTH*DEPTH-1:0] pload,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [WIDTH-1:0]       data_q,
  output logic                   busy,
  output logic                   done
);
  localparam logic [1:0] HOLD = 2'd0, SHIFT = 2'd1, ROTATE = 2'd2, LOAD = 2'd3;
  localparam int N = WIDTH * DEPTH;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [N-1:0] q, q_n, step;
  logic [LEN_W-1:0] rem, rem_n;
  logic [1:0] mode_q, mode_n, op_m;
  logic dir_q, dir_n, op_d, go, done_n;
  logic [WIDTH-1:0] fill;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      rem    <= '0;
      mode_q <= HOLD;
      dir_q  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      rem    <= rem_n;
      mode_q <= mode_n;
      dir_q  <= dir_n;
      done   <= done_n;
    end
  end
  // A burst's first step happens on the accepting edge, so RUN only covers steps 2..len.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    mode_n  = mode_q;
    dir_n   = dir_q;
    done_n  = 1'b0;
    op_m    = mode;
    op_d    = dir;
    go      = 1'b0;
    if (state == RUN) begin
      op_m  = mode_q;
      op_d  = dir_q;
      go    = 1'b1;
      rem_n = rem - LEN_W'(1);
      if (rem == LEN_W'(1)) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end else if (start && (mode == SHIFT || mode == ROTATE)) begin
      mode_n = mode;
      dir_n  = dir;
      if (len == '0) done_n = 1'b1;
      else begin
        go    = 1'b1;
        rem_n = len - LEN_W'(1);
        if (len == LEN_W'(1)) done_n = 1'b1;
        else state_n = RUN;
      end
    end else if (en) go = 1'b1;
    fill = op_m == SHIFT ? sin : (op_d ? q[WIDTH-1:0] : q[N-1 -: WIDTH]);
    step = op_d ? {fill, q[N-1:WIDTH]} : {q[N-WIDTH-1:0], fill};
    q_n  = !go || op_m == HOLD ? q : op_m == LOAD ? pload : step;
  end
  assign pout   = q;
  assign data_q = q[N-1 -: WIDTH];
  assign busy   = state == RUN;
endmodule

// File: tb/tb_shift_ring_reg.sv
// tb_shift_ring_reg: directed scenario tests for shift_ring_reg at WIDTH=4, DEPTH=4
module tb_shift_ring_reg;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, dir = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] sin = 4'h0;
  logic [15:0] pload = 16'h0;
  logic [7:0] len = 8'd0;
  logic [15:0] pout;
  logic [3:0] data_q;
  logic busy, done;
  int checks = 0, errors = 0;

  shift_ring_reg #(.WIDTH(4), .DEPTH(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .sin(sin), .pload(pload),
    .start(start), .len(len), .pout(pout), .data_q(data_q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    mode = 2'd3; pload = v; en = 1'b1;
    tick();
    en = 1'b0; mode = 2'd0;
  endtask

  task automatic test_reset;
    checks++; if (pout !== 16'h0) begin errors++; $display("FAIL rst_pout: got %h want 0000", pout); end
    checks++; if (data_q !== 4'h0) begin errors++; $display("FAIL rst_data_q: got %h want 0", data_q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    load(16'hBEEF);
    start = 1'b1; mode = 2'd2; len = 8'd5;
    tick();
    start = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (pout !== 16'h0) begin errors++; $display("FAIL midrst_pout: got %h want 0000", pout); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_load_rotate;
    load(16'h4321);
    checks++; if (pout !== 16'h4321) begin errors++; $display("FAIL load_pout: got %h want 4321", pout); end
    checks++; if (data_q !== 4'h4) begin errors++; $display("FAIL load_data_q: got %h want 4", data_q); end
    mode = 2'd2; dir = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    checks++; if (pout !== 16'h3214) begin errors++; $display("FAIL rot1_pout: got %h want 3214", pout); end
    checks++; if (data_q !== 4'h3) begin errors++; $display("FAIL rot1_data_q: got %h want 3", data_q); end
  endtask

  task automatic test_burst_rotate;
    load(16'h4321);
    start = 1'b1; mode = 2'd2; dir = 1'b0; len = 8'd4;
    tick();
    start = 1'b0; en = 1'b1; mode = 2'd3; pload = 16'h0; dir = 1'b1;
    checks++; if (busy !== 1'b1 || pout !== 16'h3214) begin errors++; $display("FAIL burst_s1: got busy=%b pout=%h want 1 3214", busy, pout); end
    tick();
    en = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || pout !== 16'h2143) begin errors++; $display("FAIL burst_s2: got busy=%b done=%b pout=%h want 1 0 2143", busy, done, pout); end
    tick();
    en = 1'b1;
    checks++; if (busy !== 1'b1 || pout !== 16'h1432) begin errors++; $display("FAIL burst_s3: got busy=%b pout=%h want 1 1432", busy, pout); end
    tick();
    en = 1'b0; mode = 2'd0;
    checks++; if (busy !== 1'b0 || done !== 1'b1 || pout !== 16'h4321) begin errors++; $display("FAIL burst_end: got busy=%b done=%b pout=%h want 0 1 4321", busy, done, pout); end
    tick();
    checks++; if (done !== 1'b0 || pout !== 16'h4321) begin errors++; $display("FAIL burst_after: got done=%b pout=%h want 0 4321", done, pout); end
  endtask

  task automatic test_shift;
    load(16'h4321);
    mode = 2'd1; dir = 1'b1; sin = 4'hA; en = 1'b1;
    tick();
    checks++; if (pout !== 16'hA432) begin errors++; $display("FAIL shift1: got %h want A432", pout); end
    tick();
    en = 1'b0;
    checks++; if (pout !== 16'hAA43) begin errors++; $display("FAIL shift2: got %h want AA43", pout); end
    start = 1'b1; mode = 2'd1; dir = 1'b0; sin = 4'h5; len = 8'd5;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++; if (pout !== 16'h5555 || done !== 1'b1) begin errors++; $display("FAIL shift_long: got pout=%h done=%b want 5555 1", pout, done); end
  endtask

  task automatic test_short_bursts;
    load(16'h4321);
    start = 1'b1; mode = 2'd2; dir = 1'b0; len = 8'd0;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || pout !== 16'h4321) begin errors++; $display("FAIL len0: got done=%b busy=%b pout=%h want 1 0 4321", done, busy, pout); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_after: got done=%b want 0", done); end
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || pout !== 16'h3214) begin errors++; $display("FAIL len1: got done=%b busy=%b pout=%h want 1 0 3214", done, busy, pout); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL len1_after: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_back_to_back;
    start = 1'b1; mode = 2'd2; dir = 1'b0; len = 8'd3;
    tick();
    mode = 2'd2; dir = 1'b1; len = 8'd1;
    checks++; if (busy !== 1'b1 || pout !== 16'h2143) begin errors++; $display("FAIL b2b_s1: got busy=%b pout=%h want 1 2143", busy, pout); end
    tick();
    checks++; if (busy !== 1'b1 || pout !== 16'h1432) begin errors++; $display("FAIL b2b_ignored_start: got busy=%b pout=%h want 1 1432", busy, pout); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || pout !== 16'h4321) begin errors++; $display("FAIL b2b_end: got done=%b busy=%b pout=%h want 1 0 4321", done, busy, pout); end
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || pout !== 16'h1432) begin errors++; $display("FAIL b2b_second: got done=%b pout=%h want 1 1432", done, pout); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_after: got done=%b want 0", done); end
  endtask

  task automatic test_abort;
    load(16'h4321);
    start = 1'b1; mode = 2'd2; dir = 1'b0; len = 8'd6;
    tick();
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || pout !== 16'h2143) begin errors++; $display("FAIL abort_pre: got busy=%b pout=%h want 1 2143", busy, pout); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (pout !== 16'h0 || data_q !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_rst: got pout=%h dq=%h busy=%b done=%b want 0000 0 0 0", pout, data_q, busy, done); end
    repeat (6) begin
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done=%b busy=%b want 0 0", done, busy); end
    end
    load(16'h4321);
    start = 1'b1; mode = 2'd2; dir = 1'b0; len = 8'd2;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || pout !== 16'h3214) begin errors++; $display("FAIL abort_next_s1: got busy=%b pout=%h want 1 3214", busy, pout); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1 || pout !== 16'h2143) begin errors++; $display("FAIL abort_next_end: got busy=%b done=%b pout=%h want 0 1 2143", busy, done, pout); end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_load_rotate();
    test_burst_rotate();
    test_shift();
    test_short_bursts();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_ring_reg.md
# shift_ring_reg

Parametrised shift/rotate register chain. It generalises the fixed four-stage, one-bit ring to WIDTH-bit stages and DEPTH stages. It adds parallel load, bidirectional shift with serial input, and a counted burst engine that performs N shift/rotate steps autonomously and signals completion. It sits in the datapath wherever a delay line, ring buffer or serialiser is needed.

## Interface
- WIDTH, default 1: bits per stage.
- DEPTH, default 4: number of stages, must be at least 2.
- LEN_W, default 8: width of the burst length input.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  single-step enable; ignored while busy.
- mode  input  2  operation: 0 HOLD, 1 SHIFT, 2 ROTATE, 3 LOAD.
- dir  input  1  direction:
  - 0: toward stage DEPTH-1.
  - 1: toward stage 0.
- sin  input  WIDTH  serial input for SHIFT.
- pload  input  WIDTH*DEPTH  parallel load data; stage i = pload[i*WIDTH +: WIDTH].
- start  input  1  begin a burst of len steps; accepted only in IDLE with mode SHIFT or ROTATE.
- len  input  LEN_W  burst step count, sampled with start.
- pout  output  WIDTH*DEPTH  all stages, same packing as pload.
- data_q  output  WIDTH  stage DEPTH-1.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse when a burst completes.

## Operation
Per-edge operations:
- HOLD: no change.
- LOAD: every stage takes its pload slice.
- dir=0:
  - Stage i takes stage i-1.
  - Stage 0 takes sin (SHIFT) or stage DEPTH-1 (ROTATE).
- dir=1:
  - Stage i takes stage i+1.
  - Stage DEPTH-1 takes sin (SHIFT) or stage 0 (ROTATE).

FSM: two states, IDLE and RUN.
- IDLE, start=1 with mode SHIFT/ROTATE:
  - Latch mode, dir and len; a 0 is required of no input.
  - The same edge performs step 1.
  - remaining = len-1.
  - If remaining > 0, go to RUN.
  - If len ≤ 1, done pulses next cycle and the FSM stays in IDLE.
- IDLE, start=1 with len=0: no step; done pulses; stay in IDLE.
- IDLE, start=1 with mode HOLD/LOAD: start is ignored and the en path applies.
- IDLE, start=0, en=1: one operation per the live mode/dir.
- IDLE, en=0: hold.
- RUN:
  - One step per edge with the latched mode/dir; sin is sampled live in SHIFT.
  - remaining decrements each step.
  - The edge that performs the last step returns to IDLE and sets done.
  - en, start, mode and dir inputs are ignored; only the latched copies are used.
- start has priority over en in IDLE.

Reset:
- All stages 0, IDLE, remaining 0.
- busy=0, done=0.
- Reset mid-burst aborts with no done pulse.

## Timing
- Reset values: pout=0, data_q=0, busy=0, done=0.
- All outputs are registered; no combinational input-to-output path.
- Single-step latency: 1 cycle; the result is visible after the edge that samples en.
- Burst accepted at edge T with len=L≥1:
  - Steps occur at edges T..T+L-1.
  - busy=1 after edges T..T+L-2.
  - busy=0 and done=1 for exactly one cycle after edge T+L-1.
- Burst with L=0: done=1 after edge T, no data change, busy never asserted.
- Back-to-back: a new start is accepted on the cycle done is high.
- L may exceed DEPTH. A ROTATE of L steps equals a rotate by L mod DEPTH. A SHIFT of L ≥ DEPTH steps leaves only sin samples in the chain.

## Test plan
- Reset: assert rst 2 cycles mid-activity -> pout=0, data_q=0, busy=0, done=0.
- Load and single rotate (WIDTH=4, DEPTH=4): LOAD pload=16'h4321 -> pout=16'h4321, data_q=4; then en ROTATE dir=0 -> pout=16'h3214, data_q=3.
- Burst rotate: from 16'h4321, start ROTATE dir=0 len=4 -> busy high 3 cycles, done high 1 cycle after 4th edge, pout=16'h4321; en toggling during RUN has no effect.
- Shift toward stage 0: from 16'h4321, en SHIFT dir=1 sin=4'hA for 2 cycles -> 16'hA432, then 16'hAA43.
- Zero/short bursts: start len=0 -> done next cycle, pout unchanged, busy never high; start len=1 ROTATE -> single step plus done, busy never high; start while busy ignored.
- Abort: start ROTATE len=6, assert rst after 2 steps -> all outputs 0 next cycle, no done pulse; next start len=2 runs normally.
